// File: rtl/dsbpm_pkg.sv
// Shared definitions for the DSBPM front-end blocks.
//   afe_spi_state_t    : receiver FSM encoding (IDLE / SHIFT / LATCH)
//   AFE_SPI_DATA_WIDTH : default payload width of one AFE SPI transfer
package dsbpm_pkg;

    localparam int AFE_SPI_DATA_WIDTH = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } afe_spi_state_t;

endpackage

// File: rtl/afe_spi_rx_if.sv
// Bundle of the AFE SPI pins and the receiver result bus.
//   spiClk/spiSdi/spiLe : serial link from the AFE (asynchronous to sysClk)
//   rxData/rxValid      : last good frame and its one-cycle update strobe
//   lengthError         : one-cycle strobe for a frame with a wrong bit count
//   frameCount          : good frames, wrapping
//   errorCount          : bad-length frames, saturating
//   busy                : receiver is shifting a frame
// Modports: master = AFE side / consumer, slave = receiver.
interface afe_spi_rx_if
    import dsbpm_pkg::*;
#(
    parameter int DATA_WIDTH  = AFE_SPI_DATA_WIDTH,
    parameter int COUNT_WIDTH = 16
);
    logic                   spiClk;
    logic                   spiSdi;
    logic                   spiLe;
    logic [DATA_WIDTH-1:0]  rxData;
    logic                   rxValid;
    logic                   lengthError;
    logic [COUNT_WIDTH-1:0] frameCount;
    logic [COUNT_WIDTH-1:0] errorCount;
    logic                   busy;

    modport master (
        output spiClk, spiSdi, spiLe,
        input  rxData, rxValid, lengthError, frameCount, errorCount, busy
    );

    modport slave (
        input  spiClk, spiSdi, spiLe,
        output rxData, rxValid, lengthError, frameCount, errorCount, busy
    );
endinterface

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin.
//   clk/rst : sysClk domain clock and asynchronous active-high reset
//   d       : asynchronous input pin
//   q       : synchronized output (STAGES flops deep)
// RESET_VAL sets the value the whole chain presets to, so an idle-high
// line (latch enable) does not show a spurious edge out of reset.
module spi_input_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_r;

    // Shift the pin through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= {STAGES{RESET_VAL}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];
endmodule

// File: rtl/afe_spi_rx.sv
// AFE SPI frame receiver, oversampled in the sysClk domain.
//   sysClk   : sole clock
//   sysReset : asynchronous active-high reset
//   spi      : afe_spi_rx_if slave (SPI pins in, frame results out)
// Pins are synchronized, edge-detected, and a three-state FSM shifts
// bits MSB-first while spiLe is low, then checks the bit count when
// spiLe rises. All result outputs are registered.
module afe_spi_rx
    import dsbpm_pkg::*;
#(
    parameter int DATA_WIDTH  = AFE_SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic        sysClk,
    input  logic        sysReset,
    afe_spi_rx_if.slave spi
);
    localparam int                     BIT_CNT_W    = $clog2(DATA_WIDTH + 2);
    localparam logic [BIT_CNT_W-1:0]   BIT_CNT_ONE  = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0]   BIT_CNT_FULL = BIT_CNT_W'(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0]   BIT_CNT_SAT  = BIT_CNT_W'(DATA_WIDTH + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE    = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX    = {COUNT_WIDTH{1'b1}};
    localparam logic [2:0]             WARM_DONE    = 3'(SYNC_STAGES);

    logic clk_sync_s, sdi_sync_s, le_sync_s;
    logic clk_prev_r, sdi_prev_r, le_prev_r;
    logic clk_rise_s, le_rise_s, le_fall_s;
    logic [2:0] warm_cnt_r;
    logic       warm_done_s;
    logic       armed_r;

    afe_spi_state_t state_r, state_next_s;
    logic shift_en_s, cnt_clr_s, latch_s, frame_ok_s;
    logic fall_pend_r, fall_pend_next_s;

    logic [BIT_CNT_W-1:0]   bit_cnt_r;
    logic [DATA_WIDTH-1:0]  shift_r;
    logic [DATA_WIDTH-1:0]  rx_data_r;
    logic                   rx_valid_r;
    logic                   length_error_r;
    logic [COUNT_WIDTH-1:0] frame_cnt_r;
    logic [COUNT_WIDTH-1:0] error_cnt_r;
    logic                   busy_r;

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .clk(sysClk), .rst(sysReset), .d(spi.spiClk), .q(clk_sync_s)
    );
    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk(sysClk), .rst(sysReset), .d(spi.spiSdi), .q(sdi_sync_s)
    );
    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_le (
        .clk(sysClk), .rst(sysReset), .d(spi.spiLe), .q(le_sync_s)
    );

    // Edge-detect registers, one per synchronized pin.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            clk_prev_r <= 1'b0;
            sdi_prev_r <= 1'b0;
            le_prev_r  <= 1'b1;
        end else begin
            clk_prev_r <= clk_sync_s;
            sdi_prev_r <= sdi_sync_s;
            le_prev_r  <= le_sync_s;
        end
    end

    assign clk_rise_s  = clk_sync_s & ~clk_prev_r;
    assign le_rise_s   = le_sync_s & ~le_prev_r;
    assign le_fall_s   = ~le_sync_s & le_prev_r;
    assign warm_done_s = (warm_cnt_r == WARM_DONE);

    // The spiLe chain presets high, so a pin held low through reset would
    // look like a falling edge. Frames may only start once a genuinely
    // sampled high level has been seen on spiLe.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            warm_cnt_r <= 3'd0;
            armed_r    <= 1'b0;
        end else begin
            if (!warm_done_s) begin
                warm_cnt_r <= warm_cnt_r + 3'd1;
            end else begin
                warm_cnt_r <= warm_cnt_r;
            end
            armed_r <= armed_r | (warm_done_s & le_sync_s);
        end
    end

    // FSM state register and the remembered LATCH-cycle falling edge.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            state_r     <= ST_IDLE;
            fall_pend_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            fall_pend_r <= fall_pend_next_s;
        end
    end

    // FSM next-state and control decode.
    always_comb begin
        state_next_s     = state_r;
        shift_en_s       = 1'b0;
        cnt_clr_s        = 1'b0;
        latch_s          = 1'b0;
        fall_pend_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((le_fall_s && armed_r) || fall_pend_r) begin
                    state_next_s = ST_SHIFT;
                    cnt_clr_s    = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // A bit arriving with the latch edge is still taken.
                shift_en_s = clk_rise_s;
                if (le_rise_s) begin
                    state_next_s = ST_LATCH;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_LATCH: begin
                latch_s          = 1'b1;
                fall_pend_next_s = le_fall_s;
                state_next_s     = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign frame_ok_s = (bit_cnt_r == BIT_CNT_FULL);

    // Bit counter (saturates one past a full frame) and shift register.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            bit_cnt_r <= '0;
            shift_r   <= '0;
        end else begin
            if (cnt_clr_s) begin
                bit_cnt_r <= '0;
            end else if (shift_en_s && (bit_cnt_r != BIT_CNT_SAT)) begin
                bit_cnt_r <= bit_cnt_r + BIT_CNT_ONE;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (shift_en_s) begin
                shift_r <= {shift_r[DATA_WIDTH-2:0], sdi_prev_r};
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    // Frame result registers, strobes and statistics counters.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            rx_data_r      <= '0;
            rx_valid_r     <= 1'b0;
            length_error_r <= 1'b0;
            frame_cnt_r    <= '0;
            error_cnt_r    <= '0;
            busy_r         <= 1'b0;
        end else begin
            rx_valid_r     <= latch_s & frame_ok_s;
            length_error_r <= latch_s & ~frame_ok_s;
            busy_r         <= (state_next_s == ST_SHIFT);
            if (latch_s && frame_ok_s) begin
                rx_data_r   <= shift_r;
                frame_cnt_r <= frame_cnt_r + COUNT_ONE;
            end else begin
                rx_data_r   <= rx_data_r;
                frame_cnt_r <= frame_cnt_r;
            end
            if (latch_s && !frame_ok_s && (error_cnt_r != COUNT_MAX)) begin
                error_cnt_r <= error_cnt_r + COUNT_ONE;
            end else begin
                error_cnt_r <= error_cnt_r;
            end
        end
    end

    assign spi.rxData      = rx_data_r;
    assign spi.rxValid     = rx_valid_r;
    assign spi.lengthError = length_error_r;
    assign spi.frameCount  = frame_cnt_r;
    assign spi.errorCount  = error_cnt_r;
    assign spi.busy        = busy_r;
endmodule

// File: tb/tb_afe_spi_rx.sv
// Self-checking bench for afe_spi_rx: drives SPI frames at sysClk/8,
// pushes the expected frame outcome when spiLe rises, and compares it
// against every rxValid/lengthError pulse.
module tb_afe_spi_rx;
    localparam int S  = 2;
    localparam int CW = 4;
    localparam int DW = 24;
    localparam int CNT_MOD = 1 << CW;

    logic sysClk;
    logic sysReset;

    afe_spi_rx_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    afe_spi_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(S), .COUNT_WIDTH(CW)) dut (
        .sysClk  (sysClk),
        .sysReset(sysReset),
        .spi     (bus)
    );

    typedef struct {
        bit          good;
        logic [23:0] data;
        int          frm;
        int          err;
        int          le_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          exp_frm  = 0;
    int          exp_err  = 0;
    logic [23:0] last_good = 24'h0;

    initial begin
        sysClk = 1'b0;
        forever #5 sysClk = ~sysClk;
    end

    // Free-running cycle count, used for latency checks.
    always @(posedge sysClk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sysClk);
    endtask

    task automatic push_expected(input logic [23:0] data, input int nbits);
        exp_t e;
        e.good = (nbits == DW);
        if (e.good) begin
            exp_frm   = (exp_frm + 1) % CNT_MOD;
            last_good = data;
        end else if (exp_err != CNT_MOD - 1) begin
            exp_err = exp_err + 1;
        end
        e.data   = last_good;
        e.frm    = exp_frm;
        e.err    = exp_err;
        e.le_cyc = cyc;
        exp_q.push_back(e);
    endtask

    // One frame: nbits clocks MSB first; coincide raises spiLe with the last clock.
    task automatic send_frame(input logic [23:0] data, input int nbits,
                              input bit coincide, input int le_high);
        logic b;
        bus.spiLe = 1'b0;
        wait_cycles(4);
        for (int i = 0; i < nbits; i++) begin
            b = (i < DW) ? data[23-i] : 1'b1;
            bus.spiSdi = b;
            bus.spiClk = 1'b0;
            wait_cycles(4);
            bus.spiClk = 1'b1;
            if (coincide && i == nbits - 1) begin
                bus.spiLe = 1'b1;
                push_expected(data, nbits);
            end
            wait_cycles(4);
        end
        if (!(coincide && nbits > 0)) begin
            bus.spiLe = 1'b1;
            push_expected(data, nbits);
        end
        wait_cycles(le_high);
    endtask

    // Scoreboard: every result pulse must match the oldest expected frame.
    always @(negedge sysClk) begin
        exp_t e;
        if (!sysReset && (bus.rxValid || bus.lengthError)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, bus.rxValid, bus.lengthError}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rxValid",     {31'd0, bus.rxValid},     {31'd0, e.good});
                check("lengthError", {31'd0, bus.lengthError}, {31'd0, ~e.good});
                check("rxData",      {8'd0, bus.rxData},       {8'd0, e.data});
                check("frameCount",  {28'd0, bus.frameCount},  32'(e.frm));
                check("errorCount",  {28'd0, bus.errorCount},  32'(e.err));
                check("latency",     32'(cyc - e.le_cyc),      32'(S + 2));
            end
        end
    end

    task automatic drain(input string tag);
        int w = 0;
        while (exp_q.size() != 0 && w < 60) begin
            @(negedge sysClk);
            w++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        wait_cycles(4);
    endtask

    initial begin
        repeat (60000) @(posedge sysClk);
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sysReset   = 1'b1;
        bus.spiClk = 1'b0;
        bus.spiSdi = 1'b0;
        bus.spiLe  = 1'b1;
        wait_cycles(3);
        sysReset = 1'b0;
        wait_cycles(8);
        check("rst_rxData",      {8'd0, bus.rxData},      32'd0);
        check("rst_rxValid",     {31'd0, bus.rxValid},    32'd0);
        check("rst_lengthError", {31'd0, bus.lengthError}, 32'd0);
        check("rst_frameCount",  {28'd0, bus.frameCount}, 32'd0);
        check("rst_errorCount",  {28'd0, bus.errorCount}, 32'd0);
        check("rst_busy",        {31'd0, bus.busy},       32'd0);

        send_frame(24'hA5C3F0, 24, 1'b0, 10);
        drain("drain_good");
        send_frame(24'h123456, 23, 1'b0, 10);
        drain("drain_short");
        send_frame(24'h654321, 30, 1'b0, 10);
        drain("drain_long");
        send_frame(24'h5A3C0F, 24, 1'b1, 10);
        drain("drain_coincide");
        send_frame(24'h000001, 24, 1'b0, 4);
        send_frame(24'hFFFFFF, 24, 1'b0, 10);
        drain("drain_b2b");
        check("b2b_rxData", {8'd0, bus.rxData}, 32'h00FFFFFF);
        send_frame(24'h0, 0, 1'b0, 10);
        drain("drain_zero");

        // Reset in the middle of a frame; raising spiLe afterwards must be silent.
        bus.spiLe = 1'b0;
        wait_cycles(4);
        for (int i = 0; i < 12; i++) begin
            bus.spiSdi = 1'b1;
            bus.spiClk = 1'b0;
            wait_cycles(4);
            bus.spiClk = 1'b1;
            wait_cycles(4);
        end
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        sysReset = 1'b1;
        exp_frm   = 0;
        exp_err   = 0;
        last_good = 24'h0;
        wait_cycles(2);
        sysReset = 1'b0;
        wait_cycles(8);
        check("rst2_busy", {31'd0, bus.busy}, 32'd0);
        bus.spiLe = 1'b1;
        wait_cycles(12);
        bus.spiClk = 1'b0;
        check("rst2_frameCount", {28'd0, bus.frameCount}, 32'd0);
        check("rst2_errorCount", {28'd0, bus.errorCount}, 32'd0);
        check("rst2_rxData",     {8'd0, bus.rxData},      32'd0);

        for (int k = 0; k < CNT_MOD + 3; k++) begin
            send_frame(24'(k), 5, 1'b0, 8);
        end
        drain("drain_bad");
        check("sat_errorCount", {28'd0, bus.errorCount}, 32'd15);
        for (int k = 0; k < 17; k++) begin
            send_frame(24'($urandom), 24, 1'b0, 8);
        end
        drain("drain_wrap");
        check("wrap_frameCount", {28'd0, bus.frameCount}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
